store_rmw_sequencer: RTL and testbench

Sequences sub-word stores to the single-ported, word-wide data memory of the execute/memory stage. It accepts one store request (byte address, store data, funct3) at a time. Byte and halfword stores are a read-modify-write: read the containing word, insert the lane, write the full word back. Word stores are written directly. It sits between the execute-stage store request and the data memory, and replaces ad-hoc read/merge/write glue with a defined handshake and FSM.

---
 rtl/store_rmw_sequencer.sv | 151 +++++++++++++++
 tb/tb_store_rmw_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_rmw_sequencer.sv
// ---------------------------------------------------------------------------
// store_rmw_sequencer : sequences SB/SH (read-modify-write) and SW stores into
// a single-ported word memory. Optional misaligned-store trap: STORE_MISALIGN_TRAP_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module store_rmw_sequencer #(
  parameter int DMEM_ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_data,
  input  logic [2:0]             req_funct3,
  output logic [DMEM_ADDR_W-1:0] mem_addr,
  output logic                   mem_rd_en,
  input  logic [31:0]            mem_rdata,
  output logic                   mem_wr_en,
  output logic [31:0]            mem_wdata,
  output logic                   store_done,
  output logic                   misaligned
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
`ifdef STORE_MISALIGN_TRAP_EN
    S_FAULT = 3'd4,
`endif
    S_WRITE = 3'd3
  } state_t;

  state_t                 state_q;
  logic [DMEM_ADDR_W-1:0] mem_addr_q;
  logic                   rd_en_q;
  logic                   wr_en_q;
  logic                   done_q;
  logic [31:0]            wdata_q;
  logic [15:0]            data_q;
  logic                   is_half_q;
  logic [1:0]             off_q;
  logic [1:0]             w_off;
  logic [31:0]            merged_d;
  logic                   w_unused_bits;

  assign w_unused_bits = ^{req_funct3[2], req_addr[31:DMEM_ADDR_W+2]};

  // Halfword lane is chosen by addr[1] alone; addr[0] never shifts it.
  assign w_off = (req_funct3[1:0] == 2'b01) ? {req_addr[1], 1'b0} : req_addr[1:0];

`ifdef STORE_MISALIGN_TRAP_EN
  logic mis_q;
  logic w_misaligned;
  assign w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        (req_funct3[1] && (req_addr[1:0] != 2'b00));
  assign misaligned   = mis_q;
`else
  assign misaligned   = 1'b0;
`endif

  always_comb begin
    merged_d = mem_rdata;
    if (is_half_q) begin
      if (off_q[1]) merged_d[31:16] = data_q;
      else          merged_d[15:0]  = data_q;
    end else begin
      case (off_q)
        2'd0:    merged_d[7:0]   = data_q[7:0];
        2'd1:    merged_d[15:8]  = data_q[7:0];
        2'd2:    merged_d[23:16] = data_q[7:0];
        default: merged_d[31:24] = data_q[7:0];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mem_addr_q <= '0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      wdata_q    <= '0;
      data_q     <= '0;
      is_half_q  <= 1'b0;
      off_q      <= '0;
`ifdef STORE_MISALIGN_TRAP_EN
      mis_q      <= 1'b0;
`endif
    end else begin
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            mem_addr_q <= req_addr[DMEM_ADDR_W+1:2];
            data_q     <= req_data[15:0];
            is_half_q  <= (req_funct3[1:0] == 2'b01);
            off_q      <= w_off;
`ifdef STORE_MISALIGN_TRAP_EN
            if (w_misaligned) begin
              mis_q   <= 1'b1;
              state_q <= S_FAULT;
            end else
`endif
            if (req_funct3[1]) begin
              wdata_q <= req_data;
              wr_en_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_WRITE;
            end else begin
              rd_en_q <= 1'b1;
              state_q <= S_READ;
            end
          end
        end
        S_READ: state_q <= S_WAIT;
        S_WAIT: begin
          wdata_q <= merged_d;
          wr_en_q <= 1'b1;
          done_q  <= 1'b1;
          state_q <= S_WRITE;
        end
        S_WRITE: state_q <= S_IDLE;
`ifdef STORE_MISALIGN_TRAP_EN
        S_FAULT: state_q <= S_IDLE;
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE) && !rst;
  assign mem_addr   = mem_addr_q;
  assign mem_rd_en  = rd_en_q;
  assign mem_wr_en  = wr_en_q;
  assign mem_wdata  = wdata_q;
  assign store_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_store_rmw_sequencer.sv
// ---------------------------------------------------------------------------
// tb_store_rmw_sequencer : scoreboard bench with a word-memory reference model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_store_rmw_sequencer;

  localparam int AW      = 10;
  localparam int K_SW    = 0;
  localparam int K_RMW   = 1;
  localparam int K_FAULT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic [31:0]   req_data;
  logic [2:0]    req_funct3;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [31:0]   mem_rdata;
  logic          mem_wr_en;
  logic [31:0]   mem_wdata;
  logic          store_done;
  logic          misaligned;

  store_rmw_sequencer #(.DMEM_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_funct3(req_funct3),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .store_done(store_done), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory seen by the DUT; read data appears the cycle after mem_rd_en.
  logic [31:0] dmem    [16];
  logic [31:0] ref_mem [16];
  logic        poke_en = 1'b0;
  logic [3:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;

  always @(posedge clk) begin
    if (poke_en)        dmem[poke_idx]      <= poke_val;
    else if (mem_wr_en) dmem[mem_addr[3:0]] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= dmem[mem_addr[3:0]];
    else           mem_rdata <= $urandom;
  end

  typedef struct {
    int            kind;
    int            acc;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (mem_rd_en || mem_wr_en || store_done || misaligned)) begin
      chk("rd_wr_exclusive", 32'(mem_rd_en & mem_wr_en), 32'd0);
      chk("done_eq_wr", 32'(store_done), 32'(mem_wr_en));
      if (q.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = q[0];
        if (mem_rd_en) begin
          chk("rd_kind",  32'(e.kind == K_RMW), 32'd1);
          chk("rd_cycle", 32'(cyc), 32'(e.acc + 1));
          chk("rd_addr",  32'(mem_addr), 32'(e.addr));
        end
        if (mem_wr_en) begin
          chk("wr_kind",  32'(e.kind != K_FAULT), 32'd1);
          chk("wr_cycle", 32'(cyc), 32'(e.acc + ((e.kind == K_RMW) ? 3 : 1)));
          chk("wr_addr",  32'(mem_addr), 32'(e.addr));
          chk("wr_data",  mem_wdata, e.data);
          void'(q.pop_front());
        end else if (misaligned) begin
          chk("fault_kind",  32'(e.kind == K_FAULT), 32'd1);
          chk("fault_cycle", 32'(cyc), 32'(e.acc + 1));
          void'(q.pop_front());
        end
      end
    end
  end

  // Issue one store; the expected outcome comes from the word-memory model.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                      input bit track, output int acc);
    exp_t        e;
    logic [31:0] w;
    bit          mis;
    int          n;
    int          lane;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_data = d; req_funct3 = f;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
`ifdef STORE_MISALIGN_TRAP_EN
    mis = ((f[1:0] == 2'b01) && a[0]) || (f[1] && (a[1:0] != 2'b00));
`else
    mis = 1'b0;
`endif
    e.acc  = acc;
    e.addr = a[AW+1:2];
    e.data = '0;
    if (mis) begin
      e.kind = K_FAULT;
    end else begin
      w = ref_mem[a[5:2]];
      if (f[1]) begin
        w = d;
      end else if (f[0]) begin
        lane = a[1] ? 16 : 0;
        w[lane +: 16] = d[15:0];
      end else begin
        lane = 8 * int'(a[1:0]);
        w[lane +: 8] = d[7:0];
      end
      e.kind = f[1] ? K_SW : K_RMW;
      e.data = w;
      if (track) ref_mem[a[5:2]] = w;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = $urandom; req_data = $urandom; req_funct3 = 3'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic set_word(input int idx, input logic [31:0] val);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = 4'(idx); poke_val = val;
    @(negedge clk);
    poke_en = 1'b0;
    ref_mem[idx] = val;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_req_ready"},  32'(req_ready),  32'd0);
    chk({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
    chk({tag, "_mem_rd_en"},  32'(mem_rd_en),  32'd0);
    chk({tag, "_mem_wr_en"},  32'(mem_wr_en),  32'd0);
    chk({tag, "_mem_wdata"},  mem_wdata,       32'd0);
    chk({tag, "_store_done"}, 32'(store_done), 32'd0);
    chk({tag, "_misaligned"}, 32'(misaligned), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1;
    int acc2;
    logic [31:0] a;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_funct3 = '0;
    for (int i = 0; i < 16; i++) set_word(i, $urandom);
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    set_word(4, 32'hAABBCCDD);
    send(32'h10, 32'h01020304, 3'b010, 1'b1, acc1);
    drain();
    for (int k = 0; k < 4; k++) begin
      set_word(4, 32'hAABBCCDD);
      send(32'h10 + 32'(k), 32'h00000011, 3'b000, 1'b1, acc1);
      drain();
    end
    set_word(4, 32'hAABBCCDD);
    send(32'h12, 32'h00001234, 3'b001, 1'b1, acc1);
    drain();
    set_word(4, 32'hAABBCCDD);
    send(32'h10, 32'h00001234, 3'b101, 1'b1, acc1);
    drain();

    set_word(4, 32'hAABBCCDD);
    send(32'h13, 32'h00000011, 3'b000, 1'b1, acc1);
    send(32'h10, 32'h01020304, 3'b010, 1'b1, acc2);
    chk("b2b_accept_gap", 32'(acc2 - acc1), 32'd4);
    drain();

    set_word(4, 32'hAABBCCDD);
    send(32'h11, 32'h00001234, 3'b001, 1'b1, acc1);
    drain();

    // Reset while the SB is waiting on read data: its write must never happen.
    set_word(4, 32'hAABBCCDD);
    send(32'h13, 32'h00000011, 3'b000, 1'b0, acc1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_idle_outputs("midrst");
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_mem_untouched", dmem[4], 32'hAABBCCDD);
    send(32'h10, 32'h01020304, 3'b010, 1'b1, acc1);
    drain();

    for (int i = 0; i < 80; i++) begin
      a = $urandom & 32'hFFFF_F03F;
      send(a, $urandom, 3'($urandom), 1'b1, acc1);
      if ($urandom_range(0, 2) == 0) drain();
      else repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    for (int i = 0; i < 16; i++) chk("final_mem", dmem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
